// File: rtl/bcd_digits_by_div10_20.sv
// rtl/bcd_digits_by_div10_20.sv - binary to packed BCD by repeated division by 10 on an external divider
module bcd_digits_by_div10_20 #(
  parameter int W  = 20,
  parameter int ND = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [W-1:0]    value,
  output logic [4*ND-1:0] bcd,
  output logic [2:0]      ndigits,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            div_start,
  output logic [W-1:0]    div_dividend,
  output logic [3:0]      div_orgdiv,
  input  logic [W-1:0]    div_result,
  input  logic            div_result_ready
);

  typedef enum logic [2:0] {IDLE, KICK, WAIT, STEP, FINISH} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    n_q, n_d;
  logic [W-1:0]    q_q, q_d;
  logic [2:0]      k_q, k_d;
  logic [4*ND-1:0] bcd_q, bcd_d;
  logic [2:0]      ndigits_q, ndigits_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            div_start_q, div_start_d;
  logic [W-1:0]    div_dividend_q, div_dividend_d;

  // q*10 is formed with 4 spare bits so an oversized quotient cannot wrap and look consistent
  logic [W+3:0] q_times_10;
  logic [W-1:0] rem;
  logic         bad_q;
  logic [3:0]   digit;

  always_comb begin
    q_times_10 = ({4'b0, q_q} << 3) + ({4'b0, q_q} << 1);
    rem        = n_q - q_times_10[W-1:0];
    bad_q      = (q_times_10 > {4'b0, n_q}) || (rem > W'(9));
    digit      = bad_q ? 4'hF : rem[3:0];
  end

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    q_d            = q_q;
    k_d            = k_q;
    bcd_d          = bcd_q;
    ndigits_d      = ndigits_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    err_d          = err_q;
    div_start_d    = 1'b0;
    div_dividend_d = div_dividend_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d            = value;
          bcd_d          = '0;
          k_d            = 3'd0;
          err_d          = 1'b0;
          busy_d         = 1'b1;
          div_start_d    = 1'b1;
          div_dividend_d = value;
          state_d        = KICK;
        end
      end
      KICK: state_d = WAIT;
      WAIT: begin
        if (div_result_ready) begin
          q_d     = div_result;
          state_d = STEP;
        end
      end
      STEP: begin
        for (int i = 0; i < ND; i++) begin
          if (k_q == 3'(i)) bcd_d[4*i +: 4] = digit;
        end
        err_d = err_q | bad_q;
        k_d   = k_q + 3'd1;
        n_d   = q_q;
        // ndigits is loaded here so it is already valid alongside the done pulse
        if (q_q == '0 || k_q == 3'(ND-1)) begin
          ndigits_d = k_q + 3'd1;
          done_d    = 1'b1;
          state_d   = FINISH;
        end else begin
          div_start_d    = 1'b1;
          div_dividend_d = q_q;
          state_d        = KICK;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      n_q            <= '0;
      q_q            <= '0;
      k_q            <= 3'd0;
      bcd_q          <= '0;
      ndigits_q      <= 3'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      div_start_q    <= 1'b0;
      div_dividend_q <= '0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      q_q            <= q_d;
      k_q            <= k_d;
      bcd_q          <= bcd_d;
      ndigits_q      <= ndigits_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      div_start_q    <= div_start_d;
      div_dividend_q <= div_dividend_d;
    end
  end

  assign bcd          = bcd_q;
  assign ndigits      = ndigits_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign div_start    = div_start_q;
  assign div_dividend = div_dividend_q;
  assign div_orgdiv   = 4'd10;

endmodule

// File: tb/tb_bcd_digits_by_div10_20.sv
// tb/tb_bcd_digits_by_div10_20.sv - scoreboard bench with a behavioural divider for bcd_digits_by_div10_20
module tb_bcd_digits_by_div10_20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [19:0] value = '0;
  logic [27:0] bcd;
  logic [2:0]  ndigits;
  logic        busy, done, err, div_start;
  logic [19:0] div_dividend;
  logic [3:0]  div_orgdiv;
  logic [19:0] div_result;
  logic        div_result_ready;

  bcd_digits_by_div10_20 dut (
    .clk(clk), .reset_n(reset_n), .start(start), .value(value),
    .bcd(bcd), .ndigits(ndigits), .busy(busy), .done(done), .err(err),
    .div_start(div_start), .div_dividend(div_dividend), .div_orgdiv(div_orgdiv),
    .div_result(div_result), .div_result_ready(div_result_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] bcd;
    logic [2:0]  nd;
    logic        err;
    int          base;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pulse_total = 0;
  bit   fault_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Divider stand-in: ready drops after start, returns dividend/10 after a random latency
  int lat_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_result_ready <= 1'b1;
      div_result       <= '0;
      lat_cnt          <= 0;
    end else if (div_start) begin
      div_result_ready <= 1'b0;
      lat_cnt          <= int'($urandom_range(1, 6));
    end else if (!div_result_ready) begin
      if (lat_cnt <= 1) begin
        div_result_ready <= 1'b1;
        div_result <= (fault_mode && div_dividend == 20'd42) ? 20'd5 : div_dividend / 20'd10;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  always @(negedge clk) if (reset_n && div_start) pulse_total++;

  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bcd", 32'(bcd), 32'(e.bcd));
        check("ndigits", 32'(ndigits), 32'(e.nd));
        check("err", 32'(err), 32'(e.err));
        check("div_start_pulses", 32'(pulse_total - e.base), 32'(e.nd));
      end
    end
  end

  function automatic exp_t ref_model(input int v, input bit flt);
    exp_t  e;
    string s;
    int    n;
    e.bcd = '0;
    e.err = 1'b0;
    e.base = 0;
    if (flt && v == 42) begin
      // 42 -> bogus quotient 5 gives an inconsistent digit F, then 5 converts normally
      e.bcd = 28'h000005F;
      e.nd  = 3'd2;
      e.err = 1'b1;
    end else begin
      s = $sformatf("%0d", v);
      n = s.len();
      for (int i = 0; i < n; i++) e.bcd[4*i +: 4] = 4'(s.getc(n - 1 - i) - 8'd48);
      e.nd = 3'(n);
    end
    return e;
  endfunction

  task automatic issue(input int v);
    exp_t e;
    int   t;
    t = 0;
    while (busy && t < 500) begin @(negedge clk); t++; end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
    e = ref_model(v, fault_mode);
    e.base = pulse_total;
    sb.push_back(e);
    start = 1'b1;
    value = 20'(v);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_cleared_on_start", 32'(err), 32'd0);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    if (sb.size() != 0) begin
      check("done_timeout", 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  task automatic convert(input int v);
    issue(v);
    wait_done();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_ndigits", 32'(ndigits), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_div_start", 32'(div_start), 32'd0);
    check("rst_div_dividend", 32'(div_dividend), 32'd0);
    check("div_orgdiv", 32'(div_orgdiv), 32'd10);
    reset_n = 1'b1;
    @(negedge clk);

    convert(0);
    convert(1048575);
    convert(10);
    convert(9);

    // second start while busy must be ignored
    issue(65536);
    repeat (3) @(negedge clk);
    start = 1'b1;
    value = 20'd777;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // reset in the WAIT of the second digit
    begin
      int base, t;
      base = pulse_total;
      issue(4321);
      t = 0;
      while (pulse_total < base + 2 && t < 200) begin @(negedge clk); t++; end
      if (pulse_total < base + 2) check("second_kick_timeout", 32'd1, 32'd0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      sb.delete();
      check("abort_bcd", 32'(bcd), 32'd0);
      check("abort_ndigits", 32'(ndigits), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_div_start", 32'(div_start), 32'd0);
      check("abort_div_dividend", 32'(div_dividend), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
    end
    convert(4321);

    fault_mode = 1'b1;
    convert(42);
    check("err_sticky", 32'(err), 32'd1);
    fault_mode = 1'b0;
    convert(7);

    for (int i = 0; i < 25; i++) begin
      int v;
      v = int'($urandom_range(0, 1048575)) >> $urandom_range(0, 19);
      convert(v);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
